secuenciador_mux_acumulador: RTL
================================

// Module: secuenciador_mux_acumulador
// PURPOSE
//  Control stage that drives Sel of the 3-in/1-out mux (Mux_3in_1out).
//  On each Inicio pulse it steps Sel 2 -> 1 -> 0, so the mux presents
//  DatoA, DatoB and DatoC in turn, and captures the mux Salida on each step.
//  It adds the three samples as signed values and publishes the sum on
//  Resultado, with a one-cycle Listo strobe.
// PARAMETERS
//  DB      16  data width of the mux Salida and of Resultado (signed, two's complement)
//  SATURA  1   1: clamp the sum to the DB-bit signed range; 0: wrap modulo 2^DB
// PORTS
//  CLK        in   1     single clock, rising edge
//  RST_N      in   1     asynchronous active-low reset
//  Inicio     in   1     start request, sampled on the rising edge of CLK
//  Dato_Mux   in   DB    Salida of Mux_3in_1out (combinational from Sel)
//  Sel        out  2     registered select to Mux_3in_1out
//  Ocupado    out  1     high while a sequence is running
//  Listo      out  1     one-cycle strobe; Resultado is valid in the same cycle
//  Resultado  out  DB    signed sum of the three samples, held until the next Listo
// BEHAVIOUR
//  Reset: RST_N=0 forces the FSM to IDLE and clears Sel, Ocupado, Listo, Resultado
//   and the internal accumulator to 0. This takes effect immediately, including
//   mid-sequence. A sequence interrupted by reset is discarded.
//  State encoding: IDLE, PASO_A, PASO_B, PASO_C, FIN. All outputs are registered.
//  IDLE:   Sel=0, Ocupado=0. If Inicio=1 at the clock edge, go to PASO_A.
//  PASO_A: Sel=2, Ocupado=1. At the edge, acc <= sext(Dato_Mux), then go to PASO_B.
//  PASO_B: Sel=1, Ocupado=1. At the edge, acc <= acc + sext(Dato_Mux), then go to PASO_C.
//  PASO_C: Sel=0, Ocupado=1. At the edge:
//           - the final sum is acc + sext(Dato_Mux);
//           - it is saturated or wrapped into Resultado;
//           - the FSM goes to FIN.
//  FIN:    Listo=1, Ocupado=0, Sel=0. The FSM returns to IDLE unconditionally.
//  Timing:
//   - Inicio is sampled at edge k.
//   - Sel=2,1,0 are driven in cycles k+1, k+2, k+3.
//   - Listo is high in cycle k+4.
//   - The earliest restart is an Inicio sampled at edge k+5, i.e. in IDLE.
//  Dato_Mux is sampled at the end of each PASO cycle. The mux is combinational,
//   so the mux settles within the same cycle and no wait state is inserted.
//  Inicio is ignored in PASO_A..FIN: no queueing and no restart.
//   A level-high Inicio retriggers on every return to IDLE.
//  Arithmetic:
//   - The accumulator is DB+2 bits signed, so the 3-term sum cannot overflow internally.
//   - SATURA=1: a sum above 2^(DB-1)-1 gives 0x7FFF (for DB=16); a sum below
//     -2^(DB-1) gives 0x8000.
//   - SATURA=0: Resultado takes the low DB bits of the accumulator.
//  Sel never takes the value 3. Resultado changes only on the PASO_C -> FIN edge.
// TESTING
//  1 Hold RST_N=0, then release it.
//     -> Sel=0, Ocupado=0, Listo=0, Resultado=0, and the FSM is in IDLE.
//  2 Mux model with A=100, B=200, C=300; pulse Inicio.
//     -> Sel reads 2,1,0 in cycles +1..+3.
//     -> Listo=1 in cycle +4 with Resultado=600.
//     -> Ocupado is high in cycles +1..+3 only.
//  3 SATURA=1 with A=B=C=0x7000.
//     -> Resultado=0x7FFF.
//    SATURA=1 with A=B=C=0x9000.
//     -> Resultado=0x8000.
//    SATURA=0 with A=B=C=0x7000.
//     -> Resultado=0x5000.
//  4 Mixed signs: A=-5, B=3, C=1.
//     -> Resultado=0xFFFF (-1).
//    A second run with A=B=C=0.
//     -> Resultado=0, and the previous value is held until that Listo.
//  5 Inicio pulses during PASO_B and during FIN.
//     -> No restart; exactly one Listo, in cycle +4.
//    Inicio held high.
//     -> A new sequence starts every 5 cycles.
//  6 Assert RST_N=0 during PASO_B.
//     -> Sel and Ocupado go to 0 immediately; Listo never fires; Resultado=0.
//    After release, pulse Inicio.
//     -> A normal 5-cycle sequence runs.

Source files
------------

// File: rtl/secuenciador_mux_acumulador.sv
`default_nettype none
// ============================================================================
// Module      : secuenciador_mux_acumulador
// Description : Steps the 3-to-1 mux select 2->1->0 on each Inicio, adds the
//               three signed samples and publishes the sum with a Listo strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_mux_acumulador #(
    parameter int DB     = 16,
    parameter bit SATURA = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Inicio,
    input  logic [DB-1:0] Dato_Mux,
    output logic [1:0]    Sel,
    output logic          Ocupado,
    output logic          Listo,
    output logic [DB-1:0] Resultado
);

    localparam int AW = DB + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PASO_A = 3'd1,
        PASO_B = 3'd2,
        PASO_C = 3'd3,
        FIN    = 3'd4
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [1:0]            sel_q, sel_d;
    logic                  ocupado_q, ocupado_d;
    logic                  listo_q, listo_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [DB-1:0]         resultado_q, resultado_d;

    logic signed [AW-1:0]  w_dato_ext;
    logic signed [AW-1:0]  w_suma;
    logic [DB-1:0]         w_suma_ajustada;

    assign w_dato_ext = {{2{Dato_Mux[DB-1]}}, Dato_Mux};
    assign w_suma     = acc_q + w_dato_ext;

    generate
        if (SATURA) begin : g_satura
            localparam logic signed [AW-1:0] c_suma_max = {3'b000, {(DB-1){1'b1}}};
            localparam logic signed [AW-1:0] c_suma_min = {3'b111, {(DB-1){1'b0}}};
            always_comb begin
                w_suma_ajustada = w_suma[DB-1:0];
                if (w_suma > c_suma_max) begin
                    w_suma_ajustada = {1'b0, {(DB-1){1'b1}}};
                end else if (w_suma < c_suma_min) begin
                    w_suma_ajustada = {1'b1, {(DB-1){1'b0}}};
                end
            end
        end else begin : g_wrap
            assign w_suma_ajustada = w_suma[DB-1:0];
        end
    endgenerate

    always_comb begin
        estado_d    = estado_q;
        acc_d       = acc_q;
        resultado_d = resultado_q;
        case (estado_q)
            IDLE: begin
                if (Inicio) begin
                    estado_d = PASO_A;
                end
            end
            PASO_A: begin
                acc_d    = w_dato_ext;
                estado_d = PASO_B;
            end
            PASO_B: begin
                acc_d    = w_suma;
                estado_d = PASO_C;
            end
            PASO_C: begin
                acc_d       = w_suma;
                resultado_d = w_suma_ajustada;
                estado_d    = FIN;
            end
            FIN: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        sel_d     = 2'd0;
        ocupado_d = 1'b0;
        listo_d   = 1'b0;
        case (estado_d)
            PASO_A: begin
                sel_d     = 2'd2;
                ocupado_d = 1'b1;
            end
            PASO_B: begin
                sel_d     = 2'd1;
                ocupado_d = 1'b1;
            end
            PASO_C: begin
                sel_d     = 2'd0;
                ocupado_d = 1'b1;
            end
            FIN: begin
                listo_d = 1'b1;
            end
            default: begin
                sel_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            estado_q    <= IDLE;
            sel_q       <= 2'd0;
            ocupado_q   <= 1'b0;
            listo_q     <= 1'b0;
            acc_q       <= '0;
            resultado_q <= '0;
        end else begin
            estado_q    <= estado_d;
            sel_q       <= sel_d;
            ocupado_q   <= ocupado_d;
            listo_q     <= listo_d;
            acc_q       <= acc_d;
            resultado_q <= resultado_d;
        end
    end

    assign Sel       = sel_q;
    assign Ocupado   = ocupado_q;
    assign Listo     = listo_q;
    assign Resultado = resultado_q;

endmodule
`default_nettype wire
